sd_cmd_arbiter: RTL and testbench

- Sits in front of the SD host command control block and sequences it.
- Shares the command control between two requesters: req0 is the software register path, req1 is the data/DMA path.
- For each granted request: latches index and argument, pulses a new command, supervises completion with a cycle timeout, and returns the response to the granted requester.

---
 rtl/sd_cmd_arbiter_if.sv | 36 +++
 rtl/sd_cmd_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sd_cmd_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_cmd_arbiter_if.sv
// Requester and command-control signals shared by sd_cmd_arbiter.
// master = arbiter view, slave = requesters plus command control.
interface sd_cmd_arbiter_if;
  logic [1:0]  iReq;
  logic [11:0] iCmd_index;
  logic [63:0] iCmd_argument;
  logic [1:0]  oGnt;
  logic [1:0]  oRsp_valid;
  logic [1:0]  iRsp_ack;
  logic [37:0] oRsp_data;
  logic        oRsp_timeout;
  logic        oRsp_index_error;
  logic        oNew_command;
  logic [5:0]  oCmd_index;
  logic [31:0] oCmd_argument;
  logic        oTimeout_enable;
  logic        oTimeout;
  logic        iIdle_out;
  logic        iCommand_complete;
  logic [37:0] iResponse;
  logic        iCommand_index_error;

  modport master (
    input  iReq, iCmd_index, iCmd_argument, iRsp_ack,
           iIdle_out, iCommand_complete, iResponse, iCommand_index_error,
    output oGnt, oRsp_valid, oRsp_data, oRsp_timeout, oRsp_index_error,
           oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout
  );

  modport slave (
    output iReq, iCmd_index, iCmd_argument, iRsp_ack,
           iIdle_out, iCommand_complete, iResponse, iCommand_index_error,
    input  oGnt, oRsp_valid, oRsp_data, oRsp_timeout, oRsp_index_error,
           oNew_command, oCmd_index, oCmd_argument, oTimeout_enable, oTimeout
  );
endinterface

// File: rtl/sd_cmd_arbiter.sv
// Round-robin arbiter/sequencer in front of the SD host command control.
// Optional: define SD_CMD_RETRY_EN to reissue once on a response index error.
module sd_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TIMER_W        = 16
) (
  input logic             iClock_host,
  input logic             iReset,
  sd_cmd_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    TOUT,
    RESP
`ifdef SD_CMD_RETRY_EN
    , REISSUE
`endif
  } state_t;

  state_t             state, next_state;
  logic [1:0]         gnt;
  logic               rr_last;
  logic [5:0]         cmd_index;
  logic [31:0]        cmd_arg;
  logic [37:0]        rsp_data;
  logic               rsp_timeout;
  logic               rsp_index_error;
  logic [TIMER_W-1:0] timer;
  logic               win;
  logic               go;
  logic               expired;
  logic               ack;
`ifdef SD_CMD_RETRY_EN
  logic               retry;
`endif

  assign go      = bus.iIdle_out && (bus.iReq != 2'b00);
  assign expired = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  assign ack     = |(bus.iRsp_ack & gnt);

  // On a tie the requester that did not win last time takes the grant.
  always_comb begin
    win = 1'b0;
    case (bus.iReq)
      2'b01:   win = 1'b0;
      2'b10:   win = 1'b1;
      default: win = ~rr_last;
    endcase
  end

  always_ff @(posedge iClock_host) begin
    if (iReset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (go) next_state = ISSUE;
      ISSUE: if (!bus.iIdle_out) next_state = WAIT;
      WAIT: begin
        // Completion takes priority over a simultaneous timer expiry.
        if (bus.iCommand_complete) begin
`ifdef SD_CMD_RETRY_EN
          next_state = (bus.iCommand_index_error && !retry) ? REISSUE : RESP;
`else
          next_state = RESP;
`endif
        end else if (expired) begin
          next_state = TOUT;
        end
      end
      TOUT:  if (bus.iIdle_out) next_state = RESP;
      RESP:  if (ack) next_state = IDLE;
`ifdef SD_CMD_RETRY_EN
      REISSUE: if (bus.iIdle_out) next_state = ISSUE;
`endif
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge iClock_host) begin
    if (iReset) begin
      gnt             <= '0;
      rr_last         <= 1'b1;
      cmd_index       <= '0;
      cmd_arg         <= '0;
      rsp_data        <= '0;
      rsp_timeout     <= 1'b0;
      rsp_index_error <= 1'b0;
      timer           <= '0;
`ifdef SD_CMD_RETRY_EN
      retry           <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            gnt       <= win ? 2'b10 : 2'b01;
            rr_last   <= win;
            cmd_index <= win ? bus.iCmd_index[11:6] : bus.iCmd_index[5:0];
            cmd_arg   <= win ? bus.iCmd_argument[63:32] : bus.iCmd_argument[31:0];
          end
        end
        ISSUE: if (!bus.iIdle_out) timer <= '0;
        WAIT: begin
          timer <= (timer == '1) ? timer : timer + 1'b1;
          // A first-attempt error headed for a retry is not latched.
          if (bus.iCommand_complete && next_state == RESP) begin
            rsp_data        <= bus.iResponse;
            rsp_index_error <= bus.iCommand_index_error;
          end
        end
        TOUT: begin
          if (bus.iIdle_out) begin
            rsp_timeout <= 1'b1;
            rsp_data    <= '0;
          end
        end
        RESP: begin
          if (ack) begin
            gnt             <= '0;
            rsp_timeout     <= 1'b0;
            rsp_index_error <= 1'b0;
`ifdef SD_CMD_RETRY_EN
            retry           <= 1'b0;
`endif
          end
        end
`ifdef SD_CMD_RETRY_EN
        REISSUE: if (bus.iIdle_out) retry <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.oNew_command    = 1'b0;
    bus.oTimeout_enable = 1'b0;
    bus.oTimeout        = 1'b0;
    bus.oRsp_valid      = '0;
    case (state)
      ISSUE: begin
        bus.oNew_command    = 1'b1;
        bus.oTimeout_enable = 1'b1;
      end
      WAIT: bus.oTimeout_enable = 1'b1;
      TOUT: begin
        bus.oTimeout_enable = 1'b1;
        bus.oTimeout        = 1'b1;
      end
      RESP: bus.oRsp_valid = gnt;
`ifdef SD_CMD_RETRY_EN
      REISSUE: bus.oTimeout_enable = 1'b1;
`endif
      default: ;
    endcase
  end

  assign bus.oGnt             = gnt;
  assign bus.oCmd_index       = cmd_index;
  assign bus.oCmd_argument    = cmd_arg;
  assign bus.oRsp_data        = rsp_data;
  assign bus.oRsp_timeout     = rsp_timeout;
  assign bus.oRsp_index_error = rsp_index_error;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: vector table of full transactions plus
// hand sequences for timeout, complete/expiry race, reset abort and index error.
module tb_sd_cmd_arbiter;

  logic clk = 1'b0;
  logic rst;
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned nc_rises = 0;
  logic        nc_prev  = 1'b0;

  sd_cmd_arbiter_if bus();

  sd_cmd_arbiter #(.TIMEOUT_CYCLES(64), .TIMER_W(16)) dut (
    .iClock_host(clk),
    .iReset     (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.oNew_command && !nc_prev) nc_rises++;
    nc_prev = bus.oNew_command;
  end

  typedef struct {
    logic [1:0]  req;
    logic [11:0] idx;
    logic [63:0] arg;
    logic [37:0] resp;
    int unsigned lat;
    int unsigned win;
    logic [5:0]  exp_idx;
    logic [31:0] exp_arg;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_a"}, {bus.oGnt, bus.oRsp_valid, bus.oRsp_timeout, bus.oRsp_index_error,
                         bus.oNew_command, bus.oTimeout_enable, bus.oTimeout, bus.oCmd_index}, 64'h0);
    check({name, "_b"}, {26'h0, bus.oRsp_data}, 64'h0);
    check({name, "_c"}, {32'h0, bus.oCmd_argument}, 64'h0);
  endtask

  task automatic grant(input logic [1:0] req, input logic [11:0] idx, input logic [63:0] arg,
                       input int unsigned exp_win);
    int unsigned n = 0;
    logic [1:0] oh;
    oh = 2'b01 << exp_win;
    bus.iReq = req;
    bus.iCmd_index = idx;
    bus.iCmd_argument = arg;
    do begin
      tick();
      n++;
    end while (bus.oGnt == 2'b00 && n < 8);
    check("grant_latency", 64'(n), 64'd1);
    check("gnt", 64'(bus.oGnt), 64'(oh));
    check("new_cmd_issue", 64'(bus.oNew_command), 64'd1);
    bus.iReq = req & ~oh;
  endtask

  task automatic do_txn(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.win;
    grant(v.req, v.idx, v.arg, v.win);
    check("cmd_index", 64'(bus.oCmd_index), 64'(v.exp_idx));
    check("cmd_arg", 64'(bus.oCmd_argument), 64'(v.exp_arg));
    check("tmo_en_issue", 64'(bus.oTimeout_enable), 64'd1);
    bus.iIdle_out = 1'b0;
    tick();
    check("new_cmd_wait", 64'(bus.oNew_command), 64'd0);
    check("tmo_en_wait", 64'(bus.oTimeout_enable), 64'd1);
    repeat (v.lat - 1) tick();
    bus.iCommand_complete = 1'b1;
    bus.iResponse = v.resp;
    tick();
    bus.iCommand_complete = 1'b0;
    bus.iResponse = '0;
    check("rsp_valid", 64'(bus.oRsp_valid), 64'(oh));
    check("rsp_data", 64'(bus.oRsp_data), 64'(v.resp));
    check("rsp_ierr", 64'(bus.oRsp_index_error), 64'd0);
    check("rsp_tout", 64'(bus.oRsp_timeout), 64'd0);
    check("tmo_en_resp", 64'(bus.oTimeout_enable), 64'd0);
    bus.iIdle_out = 1'b1;
    bus.iRsp_ack = ~oh;
    tick();
    check("wrong_ack_valid", 64'(bus.oRsp_valid), 64'(oh));
    check("wrong_ack_gnt", 64'(bus.oGnt), 64'(oh));
    bus.iRsp_ack = oh;
    tick();
    bus.iRsp_ack = 2'b00;
    check("ack_gnt", 64'(bus.oGnt), 64'd0);
    check("ack_valid", 64'(bus.oRsp_valid), 64'd0);
    check("ack_data_held", 64'(bus.oRsp_data), 64'(v.resp));
  endtask

  initial begin
    logic tout_seen;
    vec_t fresh;

    vecs[0] = '{2'b11, {6'h22, 6'h01}, {32'hBBBB0001, 32'hAAAA0001}, 38'h1111, 2, 0, 6'h01, 32'hAAAA0001};
    vecs[1] = '{2'b11, {6'h23, 6'h02}, {32'hBBBB0002, 32'hAAAA0002}, 38'h2222, 1, 1, 6'h23, 32'hBBBB0002};
    vecs[2] = '{2'b11, {6'h24, 6'h03}, {32'hBBBB0003, 32'hAAAA0003}, 38'h3FFFFFFFFF, 5, 0, 6'h03, 32'hAAAA0003};
    vecs[3] = '{2'b01, {6'h3F, 6'h11}, {32'hFFFFFFFF, 32'd5}, 38'hFF, 10, 0, 6'h11, 32'd5};
    vecs[4] = '{2'b10, {6'h15, 6'h00}, {32'h12345678, 32'h0}, 38'h2A00000001, 1, 1, 6'h15, 32'h12345678};

    bus.iReq = '0;
    bus.iCmd_index = '0;
    bus.iCmd_argument = '0;
    bus.iRsp_ack = '0;
    bus.iIdle_out = 1'b1;
    bus.iCommand_complete = 1'b0;
    bus.iResponse = '0;
    bus.iCommand_index_error = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_outputs_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 5; i++) do_txn(vecs[i]);

    // Timeout: no completion for 64 WAIT cycles.
    grant(2'b01, {6'h00, 6'h07}, {32'h0, 32'h77}, 0);
    bus.iIdle_out = 1'b0;
    tick();
    repeat (63) tick();
    check("tout_before", 64'(bus.oTimeout), 64'd0);
    tick();
    check("tout_rise", 64'(bus.oTimeout), 64'd1);
    repeat (3) tick();
    check("tout_hold", 64'(bus.oTimeout), 64'd1);
    check("tout_no_valid", 64'(bus.oRsp_valid), 64'd0);
    bus.iIdle_out = 1'b1;
    tick();
    check("tout_drop", 64'(bus.oTimeout), 64'd0);
    check("tout_rsp_flag", 64'(bus.oRsp_timeout), 64'd1);
    check("tout_rsp_data", 64'(bus.oRsp_data), 64'd0);
    check("tout_rsp_valid", 64'(bus.oRsp_valid), 64'd1);
    bus.iRsp_ack = 2'b01;
    tick();
    bus.iRsp_ack = 2'b00;
    check("tout_ack_flag", 64'(bus.oRsp_timeout), 64'd0);
    check("tout_ack_gnt", 64'(bus.oGnt), 64'd0);

    // Completion arrives in the cycle the timer expires.
    grant(2'b10, {6'h09, 6'h00}, {32'h99, 32'h0}, 1);
    bus.iIdle_out = 1'b0;
    tick();
    tout_seen = 1'b0;
    repeat (63) begin
      tick();
      tout_seen |= bus.oTimeout;
    end
    bus.iCommand_complete = 1'b1;
    bus.iResponse = 38'h0123456789;
    tick();
    bus.iCommand_complete = 1'b0;
    tout_seen |= bus.oTimeout;
    check("race_no_tout", 64'(tout_seen), 64'd0);
    check("race_rsp_tout", 64'(bus.oRsp_timeout), 64'd0);
    check("race_rsp_data", 64'(bus.oRsp_data), 64'h0123456789);
    check("race_rsp_valid", 64'(bus.oRsp_valid), 64'd2);
    bus.iIdle_out = 1'b1;
    bus.iRsp_ack = 2'b10;
    tick();
    bus.iRsp_ack = 2'b00;
    check("race_ack_gnt", 64'(bus.oGnt), 64'd0);

    // Reset pulse during WAIT aborts the transaction.
    grant(2'b10, {6'h2C, 6'h00}, {32'hCAFE, 32'h0}, 1);
    bus.iIdle_out = 1'b0;
    tick();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_outputs_zero("mid_reset");
    rst = 1'b0;
    bus.iIdle_out = 1'b1;
    fresh = '{2'b10, {6'h31, 6'h00}, {32'h31313131, 32'h0}, 38'h3131, 3, 1, 6'h31, 32'h31313131};
    do_txn(fresh);

    // Completion with index error.
    nc_rises = 0;
    grant(2'b01, {6'h00, 6'h2A}, {32'h0, 32'hDEADBEEF}, 0);
    bus.iIdle_out = 1'b0;
    tick();
    bus.iCommand_complete = 1'b1;
    bus.iCommand_index_error = 1'b1;
    bus.iResponse = 38'h3FFFFFFFFF;
    tick();
    bus.iCommand_complete = 1'b0;
    bus.iCommand_index_error = 1'b0;
    bus.iResponse = '0;
`ifdef SD_CMD_RETRY_EN
    check("retry_no_valid", 64'(bus.oRsp_valid), 64'd0);
    check("retry_no_ierr", 64'(bus.oRsp_index_error), 64'd0);
    bus.iIdle_out = 1'b1;
    tick();
    check("retry_new_cmd", 64'(bus.oNew_command), 64'd1);
    check("retry_index", 64'(bus.oCmd_index), 64'h2A);
    check("retry_arg", 64'(bus.oCmd_argument), 64'hDEADBEEF);
    bus.iIdle_out = 1'b0;
    tick();
    bus.iCommand_complete = 1'b1;
    bus.iResponse = 38'h55;
    tick();
    bus.iCommand_complete = 1'b0;
    bus.iResponse = '0;
    check("retry_valid", 64'(bus.oRsp_valid), 64'd1);
    check("retry_ierr", 64'(bus.oRsp_index_error), 64'd0);
    check("retry_data", 64'(bus.oRsp_data), 64'h55);
    check("retry_pulses", 64'(nc_rises), 64'd2);
`else
    check("ierr_valid", 64'(bus.oRsp_valid), 64'd1);
    check("ierr_flag", 64'(bus.oRsp_index_error), 64'd1);
    check("ierr_data", 64'(bus.oRsp_data), 64'h3FFFFFFFFF);
    tick();
    check("ierr_pulses", 64'(nc_rises), 64'd1);
`endif
    bus.iIdle_out = 1'b1;
    bus.iRsp_ack = 2'b01;
    tick();
    bus.iRsp_ack = 2'b00;
    check("ierr_ack_flag", 64'(bus.oRsp_index_error), 64'd0);
    check("ierr_ack_gnt", 64'(bus.oGnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
